// File: rtl/thread_fetch_unit.sv
// Fetch stage of the 4-thread barrel core: per-thread PCs, round-robin issue
// to a 1-cycle-latency instruction memory, branch/halt bookkeeping.
module thread_fetch_unit #(
  parameter int INST_ADDR_WIDTH = 9,
  parameter int THREAD_BITS     = 2,
  parameter int NUM_THREADS     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stall,
  input  logic                       branch_valid,
  input  logic [THREAD_BITS-1:0]     branch_thread,
  input  logic [INST_ADDR_WIDTH-1:0] branch_target,
  input  logic                       halt_valid,
  input  logic [THREAD_BITS-1:0]     halt_thread,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr,
  output logic                       imem_rd_en,
  output logic                       inst_valid_out,
  output logic [THREAD_BITS-1:0]     thread_id_out,
  output logic [INST_ADDR_WIDTH-1:0] pc_out,
  output logic [NUM_THREADS-1:0]     thread_done_out,
  output logic                       all_done,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int BASE_SHIFT = INST_ADDR_WIDTH - THREAD_BITS;

  state_t                     state_q, state_d;
  logic [THREAD_BITS-1:0]     rr_last_q, rr_last_d;
  logic [INST_ADDR_WIDTH-1:0] pc_q [NUM_THREADS];
  logic [INST_ADDR_WIDTH-1:0] pc_d [NUM_THREADS];
  logic [NUM_THREADS-1:0]     done_q, done_d;
  logic [INST_ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic                       rd_en_q, rd_en_d;
  logic [THREAD_BITS-1:0]     issue_tid_q, issue_tid_d;
  logic                       inst_valid_q;
  logic [THREAD_BITS-1:0]     thread_id_q;
  logic [INST_ADDR_WIDTH-1:0] pc_out_q;

  logic [NUM_THREADS-1:0]     halt_mask;
  logic [NUM_THREADS-1:0]     eligible;
  logic                       found;
  logic [THREAD_BITS-1:0]     sel;

  always_comb begin
    halt_mask = '0;
    if (halt_valid) halt_mask = NUM_THREADS'(1) << halt_thread;
    eligible = ~done_q & ~halt_mask;
    found    = 1'b0;
    sel      = '0;
    // Search starts one past the last issued thread; i == NUM_THREADS wraps to rr_last itself.
    for (int i = 1; i <= NUM_THREADS; i++) begin
      if (!found && eligible[rr_last_q + THREAD_BITS'(i)]) begin
        found = 1'b1;
        sel   = rr_last_q + THREAD_BITS'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    pc_d        = pc_q;
    done_d      = done_q;
    imem_addr_d = imem_addr_q;
    rd_en_d     = 1'b0;
    issue_tid_d = issue_tid_q;

    if (start && state_q != RUN) begin
      state_d   = RUN;
      done_d    = '0;
      rr_last_d = THREAD_BITS'(NUM_THREADS - 1);
      for (int i = 0; i < NUM_THREADS; i++) begin
        pc_d[i] = INST_ADDR_WIDTH'(i) << BASE_SHIFT;
      end
    end else begin
      done_d = done_q | halt_mask;
      if (state_q == RUN) begin
        if (!stall && found) begin
          imem_addr_d = pc_q[sel];
          rd_en_d     = 1'b1;
          rr_last_d   = sel;
          issue_tid_d = sel;
          pc_d[sel]   = pc_q[sel] + 1'b1;
        end
        if (&done_d) state_d = DONE;
      end
      // Branch lands after the increment so it overrides it; a same-cycle halt wins.
      if (branch_valid && !done_q[branch_thread] &&
          !(halt_valid && halt_thread == branch_thread)) begin
        pc_d[branch_thread] = branch_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_last_q    <= THREAD_BITS'(NUM_THREADS - 1);
      done_q       <= '0;
      imem_addr_q  <= '0;
      rd_en_q      <= 1'b0;
      issue_tid_q  <= '0;
      inst_valid_q <= 1'b0;
      thread_id_q  <= '0;
      pc_out_q     <= '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
        pc_q[i] <= INST_ADDR_WIDTH'(i) << BASE_SHIFT;
      end
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      done_q       <= done_d;
      imem_addr_q  <= imem_addr_d;
      rd_en_q      <= rd_en_d;
      issue_tid_q  <= issue_tid_d;
      inst_valid_q <= rd_en_q;
      thread_id_q  <= issue_tid_q;
      pc_out_q     <= imem_addr_q;
      pc_q         <= pc_d;
    end
  end

  assign imem_addr       = imem_addr_q;
  assign imem_rd_en      = rd_en_q;
  assign inst_valid_out  = inst_valid_q;
  assign thread_id_out   = thread_id_q;
  assign pc_out          = pc_out_q;
  assign thread_done_out = done_q;
  assign all_done        = (state_q == DONE);
  assign busy            = (state_q == RUN);

endmodule

// File: tb/tb_thread_fetch_unit.sv
// Directed bench for thread_fetch_unit: issue order, alignment, branch, halt,
// stall, completion/restart, PC wrap and mid-run reset.
module tb_thread_fetch_unit;

  logic       clk = 1'b0;
  logic       reset, start, stall, branch_valid, halt_valid;
  logic [1:0] branch_thread, halt_thread;
  logic [8:0] branch_target;
  logic [8:0] imem_addr, pc_out;
  logic       imem_rd_en, inst_valid_out, all_done, busy;
  logic [1:0] thread_id_out;
  logic [3:0] thread_done_out;

  int checks   = 0;
  int failures = 0;

  thread_fetch_unit #(.INST_ADDR_WIDTH(9), .THREAD_BITS(2), .NUM_THREADS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch_valid(branch_valid), .branch_thread(branch_thread), .branch_target(branch_target),
    .halt_valid(halt_valid), .halt_thread(halt_thread),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .inst_valid_out(inst_valid_out),
    .thread_id_out(thread_id_out), .pc_out(pc_out), .thread_done_out(thread_done_out),
    .all_done(all_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (imem_addr !== 9'd0 || imem_rd_en !== 1'b0) begin failures++;
      $display("FAIL reset_imem: addr=%0d rd_en=%0b expected 0/0", imem_addr, imem_rd_en); end
    checks++; if (inst_valid_out !== 1'b0 || pc_out !== 9'd0 || thread_id_out !== 2'd0) begin failures++;
      $display("FAIL reset_inst: valid=%0b pc=%0d tid=%0d expected 0/0/0", inst_valid_out, pc_out, thread_id_out); end
    checks++; if (thread_done_out !== 4'b0000 || all_done !== 1'b0 || busy !== 1'b0) begin failures++;
      $display("FAIL reset_status: done=%b all=%0b busy=%0b expected 0000/0/0", thread_done_out, all_done, busy); end
    tick();
    checks++; if (imem_rd_en !== 1'b0 || busy !== 1'b0) begin failures++;
      $display("FAIL idle_no_issue: rd_en=%0b busy=%0b expected 0/0", imem_rd_en, busy); end
  endtask

  task automatic test_sequence();
    int ea [8];
    ea = '{0, 128, 256, 384, 1, 129, 257, 385};
    restart();
    checks++; if (busy !== 1'b1 || imem_rd_en !== 1'b0) begin failures++;
      $display("FAIL seq_start: busy=%0b rd_en=%0b expected 1/0", busy, imem_rd_en); end
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 9'(ea[e-1])) begin failures++;
        $display("FAIL seq_issue e%0d: rd_en=%0b addr=%0d expected 1/%0d", e, imem_rd_en, imem_addr, ea[e-1]); end
      checks++; if (inst_valid_out !== (e >= 2)) begin failures++;
        $display("FAIL seq_valid e%0d: got %0b expected %0b", e, inst_valid_out, e >= 2); end
      if (e >= 2) begin
        checks++; if (pc_out !== 9'(ea[e-2]) || thread_id_out !== 2'((e-2) % 4)) begin failures++;
          $display("FAIL seq_align e%0d: pc=%0d tid=%0d expected %0d/%0d", e, pc_out, thread_id_out, ea[e-2], (e-2) % 4); end
      end
    end
  endtask

  task automatic test_branch();
    int ea [12];
    ea = '{0, 128, 256, 384, 1, 129, 257, 385, 2, 130, 40, 386};
    restart();
    for (int e = 1; e <= 12; e++) begin
      if (e == 7) begin branch_valid = 1'b1; branch_thread = 2'd2; branch_target = 9'd40; end
      tick();
      branch_valid = 1'b0;
      checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 9'(ea[e-1])) begin failures++;
        $display("FAIL branch_issue e%0d: rd_en=%0b addr=%0d expected 1/%0d", e, imem_rd_en, imem_addr, ea[e-1]); end
      if (e >= 2) begin
        checks++; if (inst_valid_out !== 1'b1 || pc_out !== 9'(ea[e-2]) || thread_id_out !== 2'((e-2) % 4)) begin failures++;
          $display("FAIL branch_align e%0d: valid=%0b pc=%0d tid=%0d expected 1/%0d/%0d", e, inst_valid_out, pc_out, thread_id_out, ea[e-2], (e-2) % 4); end
      end
    end
  endtask

  task automatic test_halt();
    int ea [10];
    int et [10];
    ea = '{0, 128, 256, 384, 1, 257, 385, 2, 258, 386};
    et = '{0, 1, 2, 3, 0, 2, 3, 0, 2, 3};
    restart();
    for (int e = 1; e <= 10; e++) begin
      if (e == 6) begin halt_valid = 1'b1; halt_thread = 2'd1; end
      tick();
      halt_valid = 1'b0;
      checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 9'(ea[e-1])) begin failures++;
        $display("FAIL halt_issue e%0d: rd_en=%0b addr=%0d expected 1/%0d", e, imem_rd_en, imem_addr, ea[e-1]); end
      if (e >= 2) begin
        checks++; if (pc_out !== 9'(ea[e-2]) || thread_id_out !== 2'(et[e-2])) begin failures++;
          $display("FAIL halt_align e%0d: pc=%0d tid=%0d expected %0d/%0d", e, pc_out, thread_id_out, ea[e-2], et[e-2]); end
      end
    end
    checks++; if (thread_done_out !== 4'b0010 || all_done !== 1'b0 || busy !== 1'b1) begin failures++;
      $display("FAIL halt_mask: done=%b all=%0b busy=%0b expected 0010/0/1", thread_done_out, all_done, busy); end
  endtask

  task automatic test_stall();
    int ea  [10];
    int erd [10];
    int et  [10];
    ea  = '{0, 128, 256, 256, 256, 256, 384, 100, 129, 257};
    erd = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
    et  = '{0, 1, 2, 0, 0, 0, 3, 0, 1, 2};
    restart();
    for (int e = 1; e <= 10; e++) begin
      stall = (e >= 4 && e <= 6);
      if (e == 5) begin branch_valid = 1'b1; branch_thread = 2'd0; branch_target = 9'd100; end
      tick();
      branch_valid = 1'b0;
      stall = 1'b0;
      checks++; if (imem_rd_en !== 1'(erd[e-1]) || imem_addr !== 9'(ea[e-1])) begin failures++;
        $display("FAIL stall_issue e%0d: rd_en=%0b addr=%0d expected %0d/%0d", e, imem_rd_en, imem_addr, erd[e-1], ea[e-1]); end
      if (e >= 2) begin
        checks++; if (inst_valid_out !== 1'(erd[e-2])) begin failures++;
          $display("FAIL stall_valid e%0d: got %0b expected %0d", e, inst_valid_out, erd[e-2]); end
        if (erd[e-2] == 1) begin
          checks++; if (pc_out !== 9'(ea[e-2]) || thread_id_out !== 2'(et[e-2])) begin failures++;
            $display("FAIL stall_align e%0d: pc=%0d tid=%0d expected %0d/%0d", e, pc_out, thread_id_out, ea[e-2], et[e-2]); end
        end
      end
    end
  endtask

  task automatic test_all_done_restart();
    int ea [3];
    int eb [4];
    ea = '{128, 256, 384};
    eb = '{0, 128, 256, 384};
    restart();
    for (int e = 1; e <= 4; e++) begin
      halt_valid = 1'b1;
      halt_thread = 2'(e - 1);
      tick();
      halt_valid = 1'b0;
      if (e <= 3) begin
        checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 9'(ea[e-1])) begin failures++;
          $display("FAIL done_issue e%0d: rd_en=%0b addr=%0d expected 1/%0d", e, imem_rd_en, imem_addr, ea[e-1]); end
      end
    end
    checks++; if (imem_rd_en !== 1'b0 || all_done !== 1'b1 || busy !== 1'b0 || thread_done_out !== 4'b1111) begin failures++;
      $display("FAIL done_state: rd_en=%0b all=%0b busy=%0b mask=%b expected 0/1/0/1111", imem_rd_en, all_done, busy, thread_done_out); end
    tick();
    tick();
    checks++; if (imem_rd_en !== 1'b0 || all_done !== 1'b1) begin failures++;
      $display("FAIL done_hold: rd_en=%0b all=%0b expected 0/1", imem_rd_en, all_done); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || all_done !== 1'b0 || thread_done_out !== 4'b0000) begin failures++;
      $display("FAIL done_restart: busy=%0b all=%0b mask=%b expected 1/0/0000", busy, all_done, thread_done_out); end
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 9'(eb[e-1])) begin failures++;
        $display("FAIL restart_issue e%0d: rd_en=%0b addr=%0d expected 1/%0d", e, imem_rd_en, imem_addr, eb[e-1]); end
    end
  endtask

  task automatic test_wrap_and_reset();
    int ea [8];
    ea = '{0, 128, 256, 511, 1, 129, 257, 0};
    restart();
    for (int e = 1; e <= 8; e++) begin
      if (e == 1) begin branch_valid = 1'b1; branch_thread = 2'd3; branch_target = 9'd511; end
      tick();
      branch_valid = 1'b0;
      checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 9'(ea[e-1])) begin failures++;
        $display("FAIL wrap_issue e%0d: rd_en=%0b addr=%0d expected 1/%0d", e, imem_rd_en, imem_addr, ea[e-1]); end
    end
    checks++; if (inst_valid_out !== 1'b1 || pc_out !== 9'd257 || thread_id_out !== 2'd2) begin failures++;
      $display("FAIL wrap_align: valid=%0b pc=%0d tid=%0d expected 1/257/2", inst_valid_out, pc_out, thread_id_out); end
    reset = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    checks++; if (imem_addr !== 9'd0 || imem_rd_en !== 1'b0 || inst_valid_out !== 1'b0 || pc_out !== 9'd0 || thread_id_out !== 2'd0) begin failures++;
      $display("FAIL midreset_out: addr=%0d rd_en=%0b valid=%0b pc=%0d tid=%0d expected all 0", imem_addr, imem_rd_en, inst_valid_out, pc_out, thread_id_out); end
    checks++; if (busy !== 1'b0 || all_done !== 1'b0 || thread_done_out !== 4'b0000) begin failures++;
      $display("FAIL midreset_state: busy=%0b all=%0b mask=%b expected 0/0/0000", busy, all_done, thread_done_out); end
    tick();
    checks++; if (imem_rd_en !== 1'b0 || inst_valid_out !== 1'b0 || busy !== 1'b0) begin failures++;
      $display("FAIL midreset_idle: rd_en=%0b valid=%0b busy=%0b expected 0/0/0", imem_rd_en, inst_valid_out, busy); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0;
    branch_valid = 1'b0; branch_thread = 2'd0; branch_target = 9'd0;
    halt_valid = 1'b0; halt_thread = 2'd0;
    test_reset();
    test_sequence();
    test_branch();
    test_halt();
    test_stall();
    test_all_done_restart();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
